// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 stream demultiplexer.
// One valid/ready input tagged with a 2-bit destination steers each accepted word into
// a one-entry register for that channel; every channel drains under its own handshake.
module demux_1_4_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3
);

    logic [3:0]   valid_q, valid_d;
    logic [W-1:0] data_q [4];
    logic [W-1:0] data_d [4];

    logic         in_fire;
    logic [3:0]   push;
    logic [3:0]   pop;

    // Input acceptance looks only at the selected channel (head-of-line blocking intended).
    always_comb begin
        in_ready = !rst && (!valid_q[in_sel] || out_ready[in_sel]);
        in_fire  = in_valid && in_ready;
    end

    // Per-channel push/pop decode and next-state; a same-edge pop and push keeps valid high.
    always_comb begin
        push    = '0;
        pop     = '0;
        valid_d = valid_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            push[i]   = in_fire && (in_sel == 2'(i));
            pop[i]    = valid_q[i] && out_ready[i];
            if (push[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end else if (pop[i]) begin
                // Data is left untouched on a pop so the last word stays visible.
                valid_d[i] = 1'b0;
            end
        end
    end

    // Channel registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Outputs come straight from the flops.
    always_comb begin
        out_valid = valid_q;
        out_data0 = data_q[0];
        out_data1 = data_q[1];
        out_data2 = data_q[2];
        out_data3 = data_q[3];
    end

endmodule

// File: doc/demux_1_4_reg.md
Name: demux_1_4_reg

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4:1 data selector.
- Accepts one valid/ready input stream tagged with a 2-bit destination select.
- Steers each accepted word into a one-entry output register for the selected channel.
- Each of the four channels drains independently under its own valid/ready handshake.

Parameters:
- W, 4, data width in bits of the input word and of every output channel.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  W  input word.
- in_sel  input  2  destination channel, 0..3.
- out_valid  output  4  bit i: channel i register holds a word.
- out_ready  input  4  bit i: channel i consumer accepts this cycle.
- out_data0  output  W  channel 0 word.
- out_data1  output  W  channel 1 word.
- out_data2  output  W  channel 2 word.
- out_data3  output  W  channel 3 word.

Behaviour:
- State per channel i: valid_i (1 bit) and data_i (W bits). out_valid[i] = valid_i; out_dataI = data_i, driven directly from flops.
- Reset: rst high asynchronously forces all valid_i = 0 and all data_i = 0, immediately and without waiting for a clock edge.
- While rst is high, in_ready = 0.
- in_ready (combinational) = !rst && (!valid[in_sel] || out_ready[in_sel]). It depends only on the selected channel; other channels' state is ignored.
- Input transfer: in_valid && in_ready at the rising edge. On transfer, data_sel <= in_data and valid_sel <= 1.
- Output transfer on channel i: out_valid[i] && out_ready[i] at the rising edge.
  - Without a simultaneous input transfer to i: valid_i <= 0; data_i holds its last value.
- Simultaneous pop and push on the same channel: valid_i stays 1 and data_i takes the new word. No bubble; full throughput per channel.
- Pushes and pops on different channels in the same cycle are independent and all take effect.
- Latency: a word accepted at edge k is visible on its channel after edge k (one cycle). No combinational path from in_data to any out_data.
- Ordering: preserved per channel; channels carry no ordering relation to each other.
- Head-of-line: a blocked word (target channel full, out_ready low) stalls the input even if other channels are free. Intended behaviour; no reordering.
- Upstream rule: while in_valid = 1 and not yet accepted, in_data and in_sel stay stable. in_valid does not drop before acceptance.
- X/Z in in_data is passed through bit-exactly. in_sel must be known whenever in_valid = 1.
- out_ready may be high while out_valid is low; this has no effect.
- Deasserting rst restores normal operation at the next edge with all channels empty.

Test Plan:
- Reset, then in_sel=0, in_data='ha, out_ready=4'b1111 -> after the edge, out_valid=4'b0001 and out_data0='ha; the next edge clears it with no new input.
- Back-to-back 'ha,'hb,'hc,'hd to sel 0,1,2,3, out_ready=4'b1111 -> in_ready stays 1; each word appears one cycle after acceptance on its own channel only; other out_data values unchanged.
- Backpressure: out_ready[2]=0; send 7 to sel 2 (accepted), then 3 to sel 2 -> in_ready=0, out_data2=7 held; raise out_ready[2] -> 7 popped and 3 loaded on the same edge, out_valid[2] stays 1, out_data2=3.
- Head-of-line: channel 1 full and not ready, input word targets sel 1 -> in_ready=0 while channels 0, 2 and 3 keep draining their words normally.
- Async reset mid-traffic: channels 0 and 3 hold 'h5 and 'h9; pulse rst between edges -> out_valid=4'b0000, all out_data=0 and in_ready=0 immediately; after release, 'h6 to sel 3 works normally.
- X passthrough: in_data='x to sel 3 -> out_data3 === 'x; sel 0, 1 and 2 outputs unaffected.
